program_launcher: RTL

- Front-end control stage directly upstream of the processor core on the labkit.
- Converts debounced button levels into one-shot program launches.
- On a launch it holds the core in reset with a stable program code on program_selector long enough for the regfile to copy it, then releases the core.
- Tracks RUN/DONE status and counts executed cycles for the 7-segment display path.

---
 rtl/program_launcher_pkg.sv | 17 +
 rtl/program_launcher_rise.sv | 11 +
 rtl/program_launcher.sv | 61 ++++++
 3 files changed

// File: rtl/program_launcher_pkg.sv
// program_launcher_pkg: status encodings, program codes and request priority encoder
package program_launcher_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;
   localparam logic [2:0] PROG_NONE = 3'd0;
   localparam logic [2:0] PROG_FIB  = 3'd1;
   localparam logic [2:0] PROG_SORT = 3'd2;
   localparam logic [2:0] PROG_LOAD = 3'd3;
   localparam logic [2:0] PROG_SAVE = 3'd4;
   function automatic logic [2:0] prog_code(input logic [3:0] req);
      return req[0] ? PROG_FIB : req[1] ? PROG_SORT : req[2] ? PROG_LOAD : req[3] ? PROG_SAVE : PROG_NONE;
   endfunction
endpackage

// File: rtl/program_launcher_rise.sv
// rise_detect: one-cycle pulse on a 0->1 level change; ports clock, reset (active-low), level in, pulse out
module rise_detect (
   input  logic clock,
   input  logic reset,
   input  logic level,
   output logic pulse
);
   logic prev;
   always_ff @(posedge clock) prev <= !reset ? 1'b1 : level;
   always_comb pulse = level & ~prev;
endmodule

// File: rtl/program_launcher.sv
// program_launcher: buttons -> one-shot launch holding cpu_reset/program_selector, RUN/DONE status, run cycle count; ports clock, reset (active-low), *_act/halted in, cpu_reset/program_selector/status/run_cycles out
module program_launcher
   import program_launcher_pkg::*;
#(
   parameter int SEL_W       = 32,
   parameter int HOLD_CYCLES = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             fib_act,
   input  logic             sort_act,
   input  logic             load_act,
   input  logic             save_act,
   input  logic             halted,
   output logic             cpu_reset,
   output logic [SEL_W-1:0] program_selector,
   output logic [1:0]       status,
   output logic [CNT_W-1:0] run_cycles
);
   logic [3:0]       lvl;
   logic [3:0]       req;
   logic             any_req;
   logic             enter;
   state_t           state;
   state_t           nxt;
   logic [2:0]       code;
   logic [7:0]       hold;
   logic [CNT_W-1:0] cnt;
   always_comb lvl = {save_act, load_act, sort_act, fib_act};
   for (genvar i = 0; i < 4; i++) begin : g_rd
      rise_detect u_rd (.clock(clock), .reset(reset), .level(lvl[i]), .pulse(req[i]));
   end
   always_comb any_req = |req;
   always_ff @(posedge clock) state <= !reset ? ST_IDLE : nxt;
   // LOAD ignores requests; elsewhere a request beats halted
   always_comb begin
      nxt = state;
      nxt = state == ST_LOAD ? (hold == 8'd0 ? ST_RUN : ST_LOAD) :
            any_req ? ST_LOAD :
            (state == ST_RUN && halted) ? ST_DONE : state;
   end
   always_comb enter = state != ST_LOAD && nxt == ST_LOAD;
   // count only cycles that stay in RUN, so the value seen when halted is frozen in DONE
   always_ff @(posedge clock)
      if (!reset) begin
         hold <= 8'd0;
         code <= PROG_NONE;
         cnt  <= '0;
      end else begin
         hold <= enter ? 8'(HOLD_CYCLES - 1) : (state == ST_LOAD && hold != 8'd0) ? hold - 8'd1 : hold;
         code <= enter ? prog_code(req) : code;
         cnt  <= enter ? '0 : (state == ST_RUN && nxt == ST_RUN && ~&cnt) ? cnt + CNT_W'(1) : cnt;
      end
   always_comb begin
      cpu_reset        = state == ST_IDLE || state == ST_LOAD;
      program_selector = state == ST_LOAD ? SEL_W'(code) : '0;
      status           = state;
      run_cycles       = cnt;
   end
endmodule
